gray_stream_decoder: RTL and testbench
======================================

GRAY_STREAM_DECODER -- requirements
Module: gray_stream_decoder

Interface
REQ-001 Parameter WIDTH, default 4, code width in bits (legal range 2..16).
REQ-002 Parameter ERRW, default 8, width of the saturating error counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 gray_in  input  WIDTH  Gray-coded sample from the upstream Gray encoder/counter.
REQ-006 in_valid  input  1  gray_in holds a valid sample.
REQ-007 in_ready  output  1  decoder accepts a sample this cycle.
REQ-008 bin_out  output  WIDTH  registered binary value of the last accepted sample.
REQ-009 out_valid  output  1  bin_out and flags hold an unconsumed result.
REQ-010 out_ready  input  1  downstream consumes the result this cycle.
REQ-011 step_up / step_dn / step_rep / step_err  output  1 each  per-result classification vs previous sample.
REQ-012 err_sticky  output  1  set on any step_err result; held until cleared.
REQ-013 err_cnt  output  ERRW  number of step_err results, saturating.
REQ-014 err_clr  input  1  synchronous clear of err_sticky and err_cnt.
REQ-015 resync  input  1  synchronous request to forget the previous sample.

Function
REQ-016 Decode: bin[WIDTH-1] = gray[WIDTH-1]; bin[i] = bin[i+1] XOR gray[i] for i below WIDTH-1.
REQ-017 in_ready = !out_valid || out_ready (combinational, one-deep output register).
REQ-018 Accept = in_valid && in_ready; result (bin_out, flags) visible with out_valid=1 on the cycle after accept: latency 1.
REQ-019 Back-to-back: out_valid=1, out_ready=1, in_valid=1 in the same cycle gives one result per cycle, no bubble.
REQ-020 out_valid=1 and out_ready=0 holds bin_out and all step flags stable.
REQ-021 out_valid falls the cycle after out_ready=1 when no new accept occurs that cycle.
REQ-022 FSM states: IDLE (no previous sample held) and TRACK (prev_bin valid).
REQ-023 IDLE, accept: result flags all 0, prev_bin <= decoded value, next state TRACK.
REQ-024 TRACK, accept: exactly one flag set: step_rep if bin == prev_bin; step_up if bin == prev_bin+1 mod 2^WIDTH; step_dn if bin == prev_bin-1 mod 2^WIDTH; otherwise step_err. prev_bin <= bin.
REQ-025 Wrap-around is legal: prev all-ones to 0 is step_up; 0 to all-ones is step_dn.
REQ-026 step_err result sets err_sticky and increments err_cnt; err_cnt holds at all-ones.
REQ-027 err_clr with a simultaneous step_err accept: clear applies first, then err_sticky=1 and err_cnt=1.
REQ-028 resync: next state IDLE, takes effect before any accept in the same cycle (that sample is treated as first); pending output is unaffected.

Reset
REQ-029 rst_n low: state IDLE, prev_bin=0, bin_out=0, out_valid=0, all step flags 0, err_sticky=0, err_cnt=0, immediately and asynchronously.
REQ-030 in_ready=1 during and after reset; reset mid-transfer discards any pending result.

Structure
REQ-031 Package gray_pkg: state enumeration (IDLE, TRACK), default WIDTH, default ERRW.
REQ-032 Combinational sub-module gray_to_bin (WIDTH parameter) implements REQ-016; the top instantiates it once.
REQ-033 The top contains FSM, output register, step classifier and error counter only; no other sub-modules.

Verification
REQ-034 Reset then stream Gray 0000,0001,0011,0010 with out_ready=1 -> bin_out 0,1,2,3 one cycle after each accept; flags none,up,up,up.
REQ-035 Stream 1000 then 0000 (bin 15 then 0), then 1000 -> step_up on wrap, then step_dn; err_sticky=0.
REQ-036 After bin 2 (0011), send 0110 (bin 4) -> step_err=1, err_sticky=1, err_cnt=1; next 0111 (bin 5) -> step_up, err_sticky stays 1.
REQ-037 Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 from the cycle after first accept, bin_out stable; release -> full-rate stream, no lost or duplicated samples.
REQ-038 Assert err_clr in the same cycle as a step_err accept -> err_cnt=1, err_sticky=1; resync then send 1111 -> all flags 0 (first sample).
REQ-039 Drop rst_n mid-stream with out_valid=1 -> out_valid, err_cnt, bin_out 0 without a clock edge; next sample classified as first.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and defaults for the Gray-code stream decoder.
// Holds the tracking-state encoding and the per-result step classification.
package gray_pkg;

    localparam int GRAY_WIDTH_DEF = 4;
    localparam int GRAY_ERRW_DEF  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } dec_state_e;

    typedef struct packed {
        logic up;
        logic dn;
        logic rep;
        logic err;
    } step_t;

endpackage

// File: rtl/gray_to_bin.sv
// Purely combinational Gray-to-binary conversion; zero latency, no flow control.
// Each binary bit is the XOR of all Gray bits at or above its position.
module gray_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    always_comb begin
        logic v_acc;
        v_acc = 1'b0;
        o_bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            v_acc    = v_acc ^ i_gray[i];
            o_bin[i] = v_acc;
        end
    end

endmodule

// File: rtl/gray_stream_decoder.sv
// Decodes a valid/ready Gray stream to binary and classifies each step vs the previous sample.
// Latency 1 through a one-deep output register; in_ready drops only while a result is held unconsumed.
module gray_stream_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEF,
    parameter int ERRW  = GRAY_ERRW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             step_up,
    output logic             step_dn,
    output logic             step_rep,
    output logic             step_err,
    output logic             err_sticky,
    output logic [ERRW-1:0]  err_cnt,
    input  logic             err_clr,
    input  logic             resync
);

    localparam logic [WIDTH-1:0] BIN_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERRW-1:0]  CNT_ONE = {{(ERRW-1){1'b0}}, 1'b1};

    dec_state_e       r_state;
    dec_state_e       w_state_eff;
    dec_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_bin_out;
    logic             r_out_valid;
    step_t            r_step;
    logic             r_err_sticky;
    logic [ERRW-1:0]  r_err_cnt;

    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_prev_inc;
    logic [WIDTH-1:0] w_prev_dec;
    logic             w_accept;
    logic             w_err_evt;
    step_t            w_step;

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_gray_to_bin (
        .i_gray (gray_in),
        .o_bin  (w_bin)
    );

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_prev_inc = r_prev + BIN_ONE;
    assign w_prev_dec = r_prev - BIN_ONE;

    // resync overrides the held state before this cycle's sample is classified
    assign w_state_eff = resync ? IDLE : r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = w_state_eff;
        if (w_accept) begin
            w_state_nxt = TRACK;
        end
    end

    always_comb begin
        w_step = '0;
        if (w_state_eff == TRACK) begin
            if (w_bin == r_prev) begin
                w_step.rep = 1'b1;
            end else if (w_bin == w_prev_inc) begin
                w_step.up = 1'b1;
            end else if (w_bin == w_prev_dec) begin
                w_step.dn = 1'b1;
            end else begin
                w_step.err = 1'b1;
            end
        end
    end

    assign w_err_evt = w_accept && w_step.err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
        end else if (w_accept) begin
            r_prev <= w_bin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_bin_out   <= '0;
            r_step      <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_bin_out   <= w_bin;
            r_step      <= w_step;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // a clear in the same cycle as an error leaves exactly that one error recorded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end else if (err_clr) begin
            r_err_sticky <= w_err_evt;
            r_err_cnt    <= w_err_evt ? CNT_ONE : '0;
        end else if (w_err_evt) begin
            r_err_sticky <= 1'b1;
            if (!(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + CNT_ONE;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign bin_out    = r_bin_out;
    assign step_up    = r_step.up;
    assign step_dn    = r_step.dn;
    assign step_rep   = r_step.rep;
    assign step_err   = r_step.err;
    assign err_sticky = r_err_sticky;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Scoreboard bench for gray_stream_decoder: reference model predicts each result at accept time.
module tb_gray_stream_decoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] gray_in;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] bin_out;
    logic       out_valid;
    logic       out_ready;
    logic       step_up;
    logic       step_dn;
    logic       step_rep;
    logic       step_err;
    logic       err_sticky;
    logic [7:0] err_cnt;
    logic       err_clr;
    logic       resync;

    typedef struct {
        logic [3:0] bin;
        logic [3:0] flg;
        logic       sticky;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         n_checks;
    int         n_fail;
    bit         m_track;
    logic [3:0] m_prev;
    logic       m_sticky;
    logic [7:0] m_cnt;

    gray_stream_decoder #(
        .WIDTH (4),
        .ERRW  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_in    (gray_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bin_out    (bin_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .step_up    (step_up),
        .step_dn    (step_dn),
        .step_rep   (step_rep),
        .step_err   (step_err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .err_clr    (err_clr),
        .resync     (resync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_g2b(input logic [3:0] g);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    task automatic model_reset();
        m_track  = 1'b0;
        m_prev   = 4'd0;
        m_sticky = 1'b0;
        m_cnt    = 8'd0;
        sb.delete();
    endtask

    // Called at the falling edge: retire the result consumed at the next rising edge, then predict any new accept.
    task automatic evaluate();
        exp_t e;
        logic [3:0] b;
        logic [3:0] f;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_val("unexpected_out", out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check_val("bin_out", bin_out, e.bin);
                check_val("flags_up_dn_rep_err", {step_up, step_dn, step_rep, step_err}, e.flg);
                check_val("err_sticky", err_sticky, e.sticky);
                check_val("err_cnt", err_cnt, e.cnt);
            end
        end
        if (resync) m_track = 1'b0;
        if (in_valid && in_ready) begin
            b = ref_g2b(gray_in);
            f = 4'b0000;
            if (m_track) begin
                if (b == m_prev)             f = 4'b0010;
                else if (b == m_prev + 4'd1) f = 4'b1000;
                else if (b == m_prev - 4'd1) f = 4'b0100;
                else                         f = 4'b0001;
            end
            m_prev  = b;
            m_track = 1'b1;
            if (err_clr) begin
                m_sticky = f[0];
                m_cnt    = f[0] ? 8'd1 : 8'd0;
            end else if (f[0]) begin
                m_sticky = 1'b1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
            e.bin = b; e.flg = f; e.sticky = m_sticky; e.cnt = m_cnt;
            sb.push_back(e);
        end else if (err_clr) begin
            m_sticky = 1'b0;
            m_cnt    = 8'd0;
        end
    endtask

    task automatic tick(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready;
        evaluate();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] b, input bit rs, input bit ec);
        bit acc;
        gray_in  = b ^ (b >> 1);
        in_valid = 1'b1;
        resync   = rs;
        err_clr  = ec;
        acc      = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) tick(acc);
        if (!acc) check_val("accept_timeout", acc, 1'b1);
        in_valid = 1'b0;
        resync   = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && (out_valid || sb.size() != 0); i++) tick(acc);
        check_val("sb_empty", sb.size(), 0);
        check_val("out_valid_drained", out_valid, 1'b0);
    endtask

    initial begin
        bit acc;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        gray_in   = 4'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        resync    = 1'b0;
        model_reset();
        #1;
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_bin_out", bin_out, 4'd0);
        check_val("rst_flags", {step_up, step_dn, step_rep, step_err}, 4'd0);
        check_val("rst_err_sticky", err_sticky, 1'b0);
        check_val("rst_err_cnt", err_cnt, 8'd0);
        check_val("rst_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // basic count 0..3, latency one cycle after the first accept
        send(4'd0, 1'b0, 1'b0);
        check_val("latency_out_valid", out_valid, 1'b1);
        check_val("latency_bin_out", bin_out, 4'd0);
        send(4'd1, 1'b0, 1'b0);
        send(4'd2, 1'b0, 1'b0);
        send(4'd3, 1'b0, 1'b0);
        drain();

        // wrap 15 -> 0 (up) and 0 -> 15 (down)
        send(4'd15, 1'b1, 1'b0);
        send(4'd0, 1'b0, 1'b0);
        send(4'd15, 1'b0, 1'b0);
        drain();

        // jump 2 -> 4 is an error, then 4 -> 5 is a normal step
        send(4'd2, 1'b1, 1'b0);
        send(4'd4, 1'b0, 1'b0);
        send(4'd5, 1'b0, 1'b0);
        drain();

        // backpressure: one accept, then five stalled cycles, then full-rate release
        out_ready = 1'b0;
        gray_in   = 4'd6 ^ (4'd6 >> 1);
        in_valid  = 1'b1;
        tick(acc);
        check_val("bp_first_accept", acc, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            check_val("bp_in_ready", in_ready, 1'b0);
            check_val("bp_bin_stable", bin_out, 4'd6);
            check_val("bp_out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        for (int b = 7; b <= 12; b++) send(4'(b), 1'b0, 1'b0);
        drain();

        // clear coinciding with an error, then resync makes the next sample first
        send(4'd3, 1'b0, 1'b1);
        drain();
        send(4'd10, 1'b1, 1'b0);
        drain();

        // error counter saturation
        for (int i = 0; i < 260; i++) send((i % 2) ? 4'd8 : 4'd0, 1'b0, 1'b0);
        drain();
        check_val("err_cnt_saturated", err_cnt, m_cnt);

        // asynchronous reset with a result pending
        out_ready = 1'b0;
        send(4'd9, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", out_valid, 1'b0);
        check_val("arst_bin_out", bin_out, 4'd0);
        check_val("arst_err_cnt", err_cnt, 8'd0);
        check_val("arst_err_sticky", err_sticky, 1'b0);
        check_val("arst_in_ready", in_ready, 1'b1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(4'd9, 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
